// File: rtl/exu_mem_skid.sv
// EX->MEM pipeline register with a 2-entry skid buffer. in_ready and out_valid
// are both registered, so downstream stalls never reach back into the ALU.
module exu_mem_skid #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned MEMOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               in_data_ok,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_result,
    input  logic [XLEN-1:0]    in_sdata,
    input  logic [RD_W-1:0]    in_rd,
    input  logic               in_wen,
    input  logic [MEMOP_W-1:0] in_memop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_result,
    output logic [XLEN-1:0]    out_sdata,
    output logic [RD_W-1:0]    out_rd,
    output logic               out_wen,
    output logic [MEMOP_W-1:0] out_memop
);

    localparam int unsigned PW = 3 * XLEN + RD_W + 1 + MEMOP_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic [PW-1:0] in_bus;
    logic          acc;
    logic          consumed;

    assign in_bus   = {in_pc, in_result, in_sdata, in_rd, in_wen, in_memop};
    assign acc      = in_valid & in_data_ok & in_ready;
    assign consumed = out_valid & out_ready;

    assign {out_pc, out_result, out_sdata, out_rd, out_wen, out_memop} = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    main_d  = in_bus;
                end
            end
            ONE: begin
                if (acc && consumed) begin
                    main_d = in_bus;
                end else if (acc) begin
                    state_d = TWO;
                    skid_d  = in_bus;
                end else if (consumed) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the skid->main shift can happen
                if (consumed) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            out_valid <= (state_d != EMPTY);
            in_ready  <= (state_d != TWO);
        end
    end

endmodule

// File: tb/tb_exu_mem_skid.sv
// Directed bench for exu_mem_skid: a negedge monitor keeps a scoreboard of
// accepted entries and checks every MEM-side consume against it.
module tb_exu_mem_skid;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;
        logic [63:0] sdata;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  memop;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_data_ok, in_ready;
    logic [63:0] in_pc, in_result, in_sdata;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [3:0]  in_memop;
    logic        out_valid, out_ready;
    logic [63:0] out_pc, out_result, out_sdata;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [3:0]  out_memop;

    int     vectors   = 0;
    int     errors    = 0;
    int     delivered = 0;
    entry_t sb[$];

    exu_mem_skid dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data_ok(in_data_ok),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_result (in_result),
        .in_sdata  (in_sdata),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .in_memop  (in_memop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_result(out_result),
        .out_sdata (out_sdata),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .out_memop (out_memop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Payload fields are derived from the result so each field is distinct per entry.
    task automatic drive(input logic v, input logic ok, input logic [63:0] r);
        in_valid   = v;
        in_data_ok = ok;
        in_result  = r;
        in_pc      = r ^ 64'h8000_0000_0000_1000;
        in_sdata   = ~r;
        in_rd      = r[8:4];
        in_wen     = r[4];
        in_memop   = r[7:4];
    endtask

    // Scoreboard: consumes are older than same-cycle accepts, so pop before push.
    always @(negedge clk) begin
        entry_t obs, exp;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                delivered++;
                vectors++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_delivery: observed result %h expected none",
                           out_result);
                end
                if (sb.size() != 0) begin
                    obs = {out_pc, out_result, out_sdata, out_rd, out_wen, out_memop};
                    exp = sb.pop_front();
                    vectors++;
                    assert (obs === exp) else begin
                        errors++;
                        $error("FAIL payload: observed %h expected %h", obs, exp);
                    end
                end
            end
            if (in_valid && in_data_ok && in_ready && !flush)
                sb.push_back({in_pc, in_result, in_sdata, in_rd, in_wen, in_memop});
            if (flush) sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, 64'h0);

        // 1: reset
        tick(); tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
        reset = 1'b0;

        // 2: streaming, one cycle latency, full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 64'(i * 16));
            tick();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_result", out_result, 64'(i * 16));
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 1'b0, 64'h0);
        tick();
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // 3: stall fills both entries, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 64'h10);
        tick();
        chk("stall_ready1", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 1'b1, 64'h20);
        tick();
        chk("stall_ready2", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 1'b1, 64'h30);
        tick();
        chk("stall_hold_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_hold_result", out_result, 64'h10);
        out_ready = 1'b1;
        tick();
        chk("drain_result2", out_result, 64'h20);
        chk("drain_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("drain_result3", out_result, 64'h30);
        drive(1'b0, 1'b0, 64'h0);
        tick();
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // 4: flush in TWO with a concurrent offer
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 64'hA1);
        tick();
        drive(1'b1, 1'b1, 64'hA2);
        tick();
        chk("flush_pre_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 1'b1, 64'hA3);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 64'h0);
        out_ready = 1'b1;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        tick(); tick();
        chk("flush_stays_empty", {63'd0, out_valid}, 64'd0);

        // 5: no accept without data_ok
        d0 = delivered;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 64'hBAD);
            tick();
            chk("nok_valid", {63'd0, out_valid}, 64'd0);
        end
        drive(1'b1, 1'b1, 64'hDEAD);
        tick();
        chk("ok_valid", {63'd0, out_valid}, 64'd1);
        chk("ok_result", out_result, 64'hDEAD);
        drive(1'b0, 1'b0, 64'h0);
        tick();
        chk("ok_once_valid", {63'd0, out_valid}, 64'd0);
        chk("ok_once_count", 64'(delivered - d0), 64'd1);

        // 6: reset in TWO beats a concurrent consume
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 64'hC1);
        tick();
        drive(1'b1, 1'b1, 64'hC2);
        tick();
        chk("rst2_pre_ready", {63'd0, in_ready}, 64'd0);
        d0 = delivered;
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 64'h0);
        tick();
        reset = 1'b0;
        chk("rst2_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_ready", {63'd0, in_ready}, 64'd1);
        chk("rst2_result", out_result, 64'd0);
        chk("rst2_pc", out_pc, 64'd0);
        tick(); tick();
        chk("rst2_stays_empty", {63'd0, out_valid}, 64'd0);
        chk("rst2_no_delivery", 64'(delivered - d0), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
